// File: rtl/led_sequencer.sv
// LED sequencer: OFF / ON / BLINK / BURST modes paced by a TICK_DIV-cycle prescaler.
// All outputs come from registers; bursts cannot be interrupted by commands.
module led_sequencer #(
   parameter int unsigned TICK_DIV = 25_000_000
) (
   input  logic       iCLK,
   input  logic       iRST,
   input  logic       iCMD_VALID,
   input  logic [1:0] iCMD_MODE,
   input  logic [3:0] iCMD_COUNT,
   output logic       oCMD_READY,
   output logic       oLED,
   output logic       oBUSY,
   output logic       oDONE
);

   localparam int unsigned CNT_W = $clog2(TICK_DIV);
   localparam logic [CNT_W-1:0] TICK_MAX = CNT_W'(TICK_DIV - 1);

   typedef enum logic [2:0] {
      S_OFF       = 3'd0,
      S_ON        = 3'd1,
      S_BLINK     = 3'd2,
      S_BURST_ON  = 3'd3,
      S_BURST_OFF = 3'd4
   } state_t;

   state_t           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       rem_q, rem_d;
   logic             led_q, led_d;
   logic             done_q, done_d;
   logic             tick;
   logic             accept;

   always_comb begin
      oCMD_READY = (state_q == S_OFF) || (state_q == S_ON) || (state_q == S_BLINK);
      oBUSY      = (state_q == S_BURST_ON) || (state_q == S_BURST_OFF);
      oLED       = led_q;
      oDONE      = done_q;
   end

   always_comb begin
      state_d = state_q;
      rem_d   = rem_q;
      led_d   = led_q;
      done_d  = 1'b0;
      tick    = (cnt_q == TICK_MAX);
      cnt_d   = tick ? '0 : cnt_q + 1'b1;
      accept  = iCMD_VALID && oCMD_READY;

      case (state_q)
         S_OFF:   led_d = 1'b0;
         S_ON:    led_d = 1'b1;
         S_BLINK: if (tick) led_d = ~led_q;
         S_BURST_ON: begin
            if (tick) begin
               state_d = S_BURST_OFF;
               led_d   = 1'b0;
            end
         end
         S_BURST_OFF: begin
            if (tick) begin
               if (rem_q > 4'd1) begin
                  rem_d   = rem_q - 4'd1;
                  state_d = S_BURST_ON;
                  led_d   = 1'b1;
               end else begin
                  rem_d   = '0;
                  state_d = S_OFF;
                  led_d   = 1'b0;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = S_OFF;
            led_d   = 1'b0;
         end
      endcase

      // Accepting a command restarts the prescaler so the new mode gets a full phase.
      if (accept) begin
         cnt_d = '0;
         case (iCMD_MODE)
            2'b00: begin state_d = S_OFF;   led_d = 1'b0; end
            2'b01: begin state_d = S_ON;    led_d = 1'b1; end
            2'b10: begin state_d = S_BLINK; led_d = 1'b1; end
            default: begin
               state_d = S_BURST_ON;
               led_d   = 1'b1;
               rem_d   = (iCMD_COUNT == 4'd0) ? 4'd1 : iCMD_COUNT;
            end
         endcase
      end
   end

   always_ff @(posedge iCLK) begin
      if (iRST) begin
         state_q <= S_OFF;
         cnt_q   <= '0;
         rem_q   <= '0;
         led_q   <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rem_q   <= rem_d;
         led_q   <= led_d;
         done_q  <= done_d;
      end
   end

endmodule
